// File: rtl/wb_pipe_target.sv
//-----------------------------------------------------------------------------
// wb_pipe_target
//   Pipelined Wishbone target with an internal word memory, an in-order
//   request queue and a programmable minimum response latency. Used as a
//   synthesizable bench endpoint behind crossbar / pass-through logic.
//
// Ports
//   clk_i, sync_rst_i      clock, synchronous active-high reset
//   itr_cyc_i/stb_i/we_i   bus cycle, strobe, write enable
//   itr_lock_i             ignored
//   itr_sel_i/adr_i/dat_i  byte selects, word address, write data
//   itr_tga_i/tgc_i        ignored tags
//   itr_tgd_i              write data tag, stored alongside each word
//   itr_ack_o/err_o/rty_o  single-cycle termination strobes
//   itr_stall_o            high while the request queue is full
//   itr_dat_o/tgd_o        read data and read data tag (held between reads)
//
// Optional build macro
//   WB_PIPE_TARGET_RTY_EN  adds input rty_inj_i; requests accepted while it
//                          is high terminate with rty. Without the macro the
//                          port is absent and itr_rty_o is constant 0.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_pipe_target #(
  parameter int ADR_WIDTH   = 16,
  parameter int DAT_WIDTH   = 16,
  parameter int SEL_WIDTH   = 2,
  parameter int TGA_WIDTH   = 1,
  parameter int TGC_WIDTH   = 1,
  parameter int TGRD_WIDTH  = 1,
  parameter int TGWD_WIDTH  = 1,
  parameter int MEM_AW      = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 2
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic                  itr_lock_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  output logic                  itr_ack_o,
  output logic                  itr_err_o,
  output logic                  itr_rty_o,
  output logic                  itr_stall_o,
  output logic [DAT_WIDTH-1:0]  itr_dat_o,
  output logic [TGRD_WIDTH-1:0] itr_tgd_o
`ifdef WB_PIPE_TARGET_RTY_EN
  ,
  input  logic                  rty_inj_i
`endif
);

  localparam int PW        = $clog2(QUEUE_DEPTH);
  localparam int CW        = PW + 1;
  localparam int MEM_WORDS = 2 ** MEM_AW;
  localparam int TG_MIN    = (TGRD_WIDTH < TGWD_WIDTH) ? TGRD_WIDTH : TGWD_WIDTH;

  localparam logic [3:0]    LAT_CD = 4'(LATENCY);
  localparam logic [CW-1:0] FULL   = CW'(QUEUE_DEPTH);

  typedef struct packed {
    logic                  we;
    logic [SEL_WIDTH-1:0]  sel;
    logic [MEM_AW-1:0]     adr;
    logic [DAT_WIDTH-1:0]  dat;
    logic [TGWD_WIDTH-1:0] tgd;
    logic                  err;
    logic                  rty;
    logic [3:0]            cd;
  } entry_t;

  entry_t                r_q [QUEUE_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  r_ack;
  logic                  r_err;
  logic                  r_rty;
  logic [DAT_WIDTH-1:0]  r_dat;
  logic [TGRD_WIDTH-1:0] r_tgd;

  logic [DAT_WIDTH-1:0]  r_mem     [MEM_WORDS];
  logic [TGWD_WIDTH-1:0] r_mem_tgd [MEM_WORDS];

  logic                  w_rty_inj;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_adr_oor;
  logic                  w_head_commit;
  entry_t                w_head;
  entry_t                w_new;
  logic [TGWD_WIDTH-1:0] w_word_tgd;
  logic [TGRD_WIDTH-1:0] w_rd_tgd;
  logic                  w_unused;

`ifdef WB_PIPE_TARGET_RTY_EN
  assign w_rty_inj = rty_inj_i;
  assign itr_rty_o = r_rty;
  assign w_unused  = ^{itr_lock_i, itr_tga_i, itr_tgc_i};
`else
  assign w_rty_inj = 1'b0;
  assign itr_rty_o = 1'b0;
  assign w_unused  = ^{itr_lock_i, itr_tga_i, itr_tgc_i, r_rty};
`endif

  // Stall looks only at the registered count: a pop in the same cycle does
  // not open a slot until the next cycle.
  assign w_stall   = (r_count == FULL);
  assign w_accept  = itr_cyc_i & itr_stb_i & ~w_stall;

  // Any address bit at or above MEM_AW marks the request as out of range.
  assign w_adr_oor = ((itr_adr_i >> MEM_AW) != '0);

  assign w_head    = r_q[r_rd_ptr];
  assign w_pop     = itr_cyc_i & (r_count != '0) & (w_head.cd == '0);

  // Writes land in memory at the pop edge, so later reads see them.
  assign w_head_commit = ~sync_rst_i & w_pop & w_head.we & ~w_head.err & ~w_head.rty;

  always_comb begin
    w_new     = '0;
    w_new.we  = itr_we_i;
    w_new.sel = itr_sel_i;
    w_new.adr = itr_adr_i[MEM_AW-1:0];
    w_new.dat = itr_dat_i;
    w_new.tgd = itr_tgd_i;
    w_new.err = w_adr_oor;
    w_new.rty = w_rty_inj;
    w_new.cd  = LAT_CD;
  end

  // Read tag is zero-extended or truncated to the read tag width.
  assign w_word_tgd = r_mem_tgd[w_head.adr];
  always_comb begin
    w_rd_tgd = '0;
    for (int i = 0; i < TG_MIN; i++) begin
      w_rd_tgd[i] = w_word_tgd[i];
    end
  end

  // Queue payload and per-entry countdowns; no reset needed since validity
  // is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (r_q[i].cd != '0) begin
        r_q[i].cd <= r_q[i].cd - 4'd1;
      end
    end
    if (w_accept) begin
      r_q[r_wr_ptr] <= w_new;
    end
  end

  // Word memory is intentionally not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (w_head_commit) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (w_head.sel[b]) begin
          r_mem[w_head.adr][b*8 +: 8] <= w_head.dat[b*8 +: 8];
        end
      end
      r_mem_tgd[w_head.adr] <= w_head.tgd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rty    <= 1'b0;
      r_dat    <= '0;
      r_tgd    <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_rty <= 1'b0;
      if (!itr_cyc_i) begin
        // Dropping cyc abandons everything still queued.
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
          if (w_head.rty) begin
            r_rty <= 1'b1;
            r_dat <= '0;
          end else if (w_head.err) begin
            r_err <= 1'b1;
            r_dat <= '0;
          end else begin
            r_ack <= 1'b1;
            if (!w_head.we) begin
              r_dat <= r_mem[w_head.adr];
              r_tgd <= w_rd_tgd;
            end
          end
        end
        case ({w_accept, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign itr_ack_o   = r_ack;
  assign itr_err_o   = r_err;
  assign itr_stall_o = w_stall;
  assign itr_dat_o   = r_dat;
  assign itr_tgd_o   = r_tgd;

endmodule

// File: tb/tb_wb_pipe_target.sv
`timescale 1ns/1ps
module tb_wb_pipe_target;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int SW  = 2;
  localparam int MAW = 8;
  localparam int QD  = 4;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          sync_rst_i = 1'b0;
  logic          itr_cyc_i = 1'b0;
  logic          itr_stb_i = 1'b0;
  logic          itr_we_i = 1'b0;
  logic          itr_lock_i = 1'b0;
  logic [SW-1:0] itr_sel_i = '0;
  logic [AW-1:0] itr_adr_i = '0;
  logic [DW-1:0] itr_dat_i = '0;
  logic          itr_tga_i = 1'b0;
  logic          itr_tgc_i = 1'b0;
  logic          itr_tgd_i = 1'b0;
  logic          itr_ack_o;
  logic          itr_err_o;
  logic          itr_rty_o;
  logic          itr_stall_o;
  logic [DW-1:0] itr_dat_o;
  logic          itr_tgd_o;

  always #5 clk = ~clk;

  wb_pipe_target #(
    .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW), .TGA_WIDTH(1), .TGC_WIDTH(1),
    .TGRD_WIDTH(1), .TGWD_WIDTH(1), .MEM_AW(MAW), .QUEUE_DEPTH(QD), .LATENCY(LAT)
  ) dut (
    .clk_i(clk), .sync_rst_i(sync_rst_i),
    .itr_cyc_i(itr_cyc_i), .itr_stb_i(itr_stb_i), .itr_we_i(itr_we_i),
    .itr_lock_i(itr_lock_i), .itr_sel_i(itr_sel_i), .itr_adr_i(itr_adr_i),
    .itr_dat_i(itr_dat_i), .itr_tga_i(itr_tga_i), .itr_tgc_i(itr_tgc_i),
    .itr_tgd_i(itr_tgd_i), .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o),
    .itr_rty_o(itr_rty_o), .itr_stall_o(itr_stall_o), .itr_dat_o(itr_dat_o),
    .itr_tgd_o(itr_tgd_o)
`ifdef WB_PIPE_TARGET_RTY_EN
    , .rty_inj_i(1'b0)
`endif
  );

  // One accepted request and the edge at which it must be popped.
  typedef struct {
    bit          we;
    bit          err;
    logic [1:0]  sel;
    logic [15:0] adr;
    logic [15:0] dat;
    logic        tgd;
    int          due;
    bit          hc;
    logic [15:0] cv;
  } req_t;

  req_t        sb[$];
  logic [15:0] mmem [256];
  logic        mtgd [256];
  int          edge_cnt = 0;
  int          last_pop = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Drive one cycle of stimulus at a negedge; predict acceptance from the
  // number of requests not yet popped by the coming edge.
  task automatic issue(input bit c, input bit s, input bit w, input logic [1:0] sel,
                       input logic [15:0] adr, input logic [15:0] dat, input logic tg,
                       input bit hc, input logic [15:0] cv, output bit acc);
    int   e;
    int   cnt;
    bit   st;
    req_t r;
    e   = edge_cnt + 1;
    cnt = 0;
    foreach (sb[i]) if (sb[i].due >= e) cnt++;
    st = (cnt == QD);
    check(itr_stall_o == st, "stall", 32'(itr_stall_o), 32'(st));
    itr_cyc_i  = c;
    itr_stb_i  = s;
    itr_we_i   = w;
    itr_sel_i  = sel;
    itr_adr_i  = adr;
    itr_dat_i  = dat;
    itr_tgd_i  = tg;
    itr_lock_i = 1'($urandom);
    itr_tga_i  = 1'($urandom);
    itr_tgc_i  = 1'($urandom);
    acc = 1'b0;
    if (!c) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due >= e) sb.delete(i);
      last_pop = 0;
    end else if (s && !st) begin
      r.we  = w;
      r.err = (int'(adr) >= (1 << MAW));
      r.sel = sel;
      r.adr = adr;
      r.dat = dat;
      r.tgd = tg;
      r.hc  = hc;
      r.cv  = cv;
      r.due = (e + LAT + 1 > last_pop + 1) ? e + LAT + 1 : last_pop + 1;
      last_pop = r.due;
      sb.push_back(r);
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic req(input bit w, input logic [1:0] sel, input logic [15:0] adr,
                     input logic [15:0] dat, input logic tg, input bit hc, input logic [15:0] cv);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      issue(1'b1, 1'b1, w, sel, adr, dat, tg, hc, cv, acc);
      tries++;
    end
  endtask

  task automatic idle(input int n, input bit c);
    bit acc;
    for (int i = 0; i < n; i++) issue(c, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, acc);
  endtask

  task automatic do_reset(input int n);
    int e;
    e = edge_cnt + 1;
    sync_rst_i = 1'b1;
    itr_cyc_i  = 1'b0;
    itr_stb_i  = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due >= e) sb.delete(i);
    last_pop = 0;
    repeat (n) @(negedge clk);
    sync_rst_i = 1'b0;
    check(itr_ack_o == 1'b0, "rst_ack", 32'(itr_ack_o), 32'd0);
    check(itr_err_o == 1'b0, "rst_err", 32'(itr_err_o), 32'd0);
    check(itr_rty_o == 1'b0, "rst_rty", 32'(itr_rty_o), 32'd0);
    check(itr_stall_o == 1'b0, "rst_stall", 32'(itr_stall_o), 32'd0);
    check(itr_dat_o == 16'h0, "rst_dat", 32'(itr_dat_o), 32'd0);
    check(itr_tgd_o == 1'b0, "rst_tgd", 32'(itr_tgd_o), 32'd0);
  endtask

  // Monitor: every termination strobe must match the oldest outstanding
  // request, at exactly its predicted edge, with data from the model memory.
  initial begin
    req_t r;
    int   idx;
    bit   resp;
    forever begin
      @(negedge clk);
      resp = (itr_ack_o === 1'b1) || (itr_err_o === 1'b1) || (itr_rty_o === 1'b1);
      if (resp) begin
        check(sb.size() > 0, "spurious_resp", 32'({itr_ack_o, itr_err_o, itr_rty_o}), 32'd0);
        if (sb.size() > 0) begin
          r   = sb.pop_front();
          idx = int'(r.adr[7:0]);
          check(r.due == edge_cnt, "resp_cycle", 32'(edge_cnt), 32'(r.due));
          check(itr_rty_o == 1'b0, "rty_low", 32'(itr_rty_o), 32'd0);
          if (r.err) begin
            check(itr_err_o == 1'b1 && itr_ack_o == 1'b0, "err_resp",
                  32'({itr_ack_o, itr_err_o}), 32'b01);
            check(itr_dat_o == 16'h0, "err_dat", 32'(itr_dat_o), 32'd0);
          end else begin
            check(itr_ack_o == 1'b1 && itr_err_o == 1'b0, "ack_resp",
                  32'({itr_ack_o, itr_err_o}), 32'b10);
            if (r.we) begin
              for (int b = 0; b < 2; b++) if (r.sel[b]) mmem[idx][b*8 +: 8] = r.dat[b*8 +: 8];
              mtgd[idx] = r.tgd;
            end else begin
              check(itr_dat_o == mmem[idx], "rd_dat", 32'(itr_dat_o), 32'(mmem[idx]));
              check(itr_tgd_o == mtgd[idx], "rd_tgd", 32'(itr_tgd_o), 32'(mtgd[idx]));
              if (r.hc) check(itr_dat_o == r.cv, "rd_const", 32'(itr_dat_o), 32'(r.cv));
            end
          end
        end
      end else if (sb.size() > 0) begin
        check(sb[0].due > edge_cnt, "missing_resp", 32'(edge_cnt), 32'(sb[0].due));
        if (sb[0].due <= edge_cnt) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          acc;
    logic [15:0] a;
    do_reset(2);

    // Preload every word so the model memory is fully known.
    for (int i = 0; i < 256; i++) req(1'b1, 2'b11, 16'(i), 16'($urandom), 1'($urandom), 1'b0, 16'h0);
    idle(8, 1'b1);

    // Write then read back the same word on the next cycle.
    req(1'b1, 2'b11, 16'h0005, 16'hBEEF, 1'b1, 1'b0, 16'h0);
    req(1'b0, 2'b00, 16'h0005, 16'h0, 1'b0, 1'b1, 16'hBEEF);
    idle(6, 1'b1);

    // Byte-lane merge.
    req(1'b1, 2'b11, 16'h0007, 16'h1234, 1'b0, 1'b0, 16'h0);
    req(1'b1, 2'b10, 16'h0007, 16'hAB00, 1'b1, 1'b0, 16'h0);
    req(1'b0, 2'b00, 16'h0007, 16'h0, 1'b0, 1'b1, 16'hAB34);
    idle(6, 1'b1);

    // Back-to-back reads with strobe held.
    for (int i = 0; i < 6; i++) req(1'b0, 2'b00, 16'(16'h20 + i), 16'h0, 1'b0, 1'b0, 16'h0);
    idle(8, 1'b1);

    // Out-of-range accesses must not alias onto low memory.
    req(1'b0, 2'b00, 16'h0100, 16'h0, 1'b0, 1'b0, 16'h0);
    req(1'b1, 2'b11, 16'h0100, 16'hFFFF, 1'b1, 1'b0, 16'h0);
    req(1'b0, 2'b00, 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0);
    idle(6, 1'b1);

    // Abort: three reads queued, cyc dropped one cycle after the last accept.
    for (int i = 0; i < 3; i++) req(1'b0, 2'b00, 16'(16'h40 + i), 16'h0, 1'b0, 1'b0, 16'h0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(6, 1'b0);
    req(1'b0, 2'b00, 16'h0041, 16'h0, 1'b0, 1'b0, 16'h0);
    idle(6, 1'b1);

    // Reset with two writes pending; old contents must survive.
    req(1'b1, 2'b11, 16'h0030, 16'h5A5A, 1'b1, 1'b0, 16'h0);
    req(1'b1, 2'b11, 16'h0031, 16'hA5A5, 1'b1, 1'b0, 16'h0);
    do_reset(1);
    idle(6, 1'b1);
    req(1'b0, 2'b00, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0);
    req(1'b0, 2'b00, 16'h0031, 16'h0, 1'b0, 1'b0, 16'h0);
    idle(6, 1'b1);

    // Randomized traffic with occasional cyc drops and resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(199, 0) == 0) begin
        do_reset(1);
      end else begin
        if ($urandom_range(9, 0) == 0) a = 16'($urandom_range(65535, 256));
        else a = 16'($urandom_range(255, 0));
        issue(($urandom_range(24, 0) != 0), ($urandom_range(9, 0) < 7), 1'($urandom),
              2'($urandom), a, 16'($urandom), 1'($urandom), 1'b0, 16'h0, acc);
      end
    end

    idle(LAT + QD + 6, 1'b1);
    check(sb.size() == 0, "drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
